// File: rtl/sb_alloc_ctrl.sv
// Store-buffer allocation controller: in-order SB IDs for rename, commit/drain tracking, flush.
// Optional macro SB_ALLOC_BYPASS_EN lets a same-cycle drain free an entry for allocation.
module sb_alloc_ctrl #(
  parameter int unsigned SB_DEPTH     = 16,
  parameter int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH),
  parameter int unsigned CNT_WIDTH    = SB_IDX_WIDTH + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [3:0]                   alloc_req_i,
  input  logic                         alloc_fire_i,
  output logic                         alloc_ready_o,
  output logic [3:0][SB_IDX_WIDTH-1:0] alloc_id_o,
  input  logic [3:0]                   commit_store_i,
  output logic                         drain_valid_o,
  output logic [SB_IDX_WIDTH-1:0]      drain_id_o,
  input  logic                         drain_ready_i,
  input  logic                         flush_i,
  output logic [CNT_WIDTH-1:0]         used_cnt_o,
  output logic [CNT_WIDTH-1:0]         cmt_cnt_o
);

  localparam int unsigned FreeWidth = CNT_WIDTH + 1;

  logic [SB_IDX_WIDTH-1:0] head_q, head_d;
  logic [SB_IDX_WIDTH-1:0] cmt_q, cmt_d;
  logic [SB_IDX_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]    used_q, used_d;
  logic [CNT_WIDTH-1:0]    cmt_cnt_q, cmt_cnt_d;

  logic [2:0]              n_req;
  logic [2:0]              n_cmt;
  logic [2:0]              alloc_n;
  logic [2:0]              lane_ofs;
  logic                    drain_fire;
  logic                    alloc_take;
  logic [FreeWidth-1:0]    free_cnt;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign n_req = popcnt4(alloc_req_i);
  assign n_cmt = popcnt4(commit_store_i);

  // Requesting lanes get consecutive IDs from tail, oldest lane first; idle lanes read 0.
  always_comb begin
    lane_ofs = 3'd0;
    for (int i = 0; i < 4; i++) begin
      alloc_id_o[i] = '0;
      if (alloc_req_i[i]) begin
        alloc_id_o[i] = tail_q + SB_IDX_WIDTH'(lane_ofs);
        lane_ofs      = lane_ofs + 3'd1;
      end
    end
  end

  assign drain_valid_o = (cmt_cnt_q != '0);
  assign drain_fire    = drain_valid_o && drain_ready_i;
  assign drain_id_o    = head_q;
  assign used_cnt_o    = used_q;
  assign cmt_cnt_o     = cmt_cnt_q;

`ifdef SB_ALLOC_BYPASS_EN
  assign free_cnt = FreeWidth'(SB_DEPTH) - FreeWidth'(used_q) + FreeWidth'(drain_fire);
`else
  // Registered occupancy only: keeps drain_ready_i off the alloc_ready_o path.
  assign free_cnt = FreeWidth'(SB_DEPTH) - FreeWidth'(used_q);
`endif

  assign alloc_ready_o = (free_cnt >= FreeWidth'(n_req));
  assign alloc_take    = alloc_fire_i && alloc_ready_o && !flush_i;
  assign alloc_n       = alloc_take ? n_req : 3'd0;

  always_comb begin
    head_d    = head_q + SB_IDX_WIDTH'(drain_fire);
    cmt_d     = cmt_q + SB_IDX_WIDTH'(n_cmt);
    cmt_cnt_d = cmt_cnt_q + CNT_WIDTH'(n_cmt) - CNT_WIDTH'(drain_fire);
    tail_d    = tail_q + SB_IDX_WIDTH'(alloc_n);
    used_d    = used_q + CNT_WIDTH'(alloc_n) - CNT_WIDTH'(drain_fire);
    if (flush_i) begin
      // Same-cycle commits are older than the flush and survive; speculative tail is cut back.
      tail_d = cmt_d;
      used_d = cmt_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      cmt_q     <= '0;
      tail_q    <= '0;
      used_q    <= '0;
      cmt_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      cmt_q     <= cmt_d;
      tail_q    <= tail_d;
      used_q    <= used_d;
      cmt_cnt_q <= cmt_cnt_d;
    end
  end

  // Rename may only fire a group that fits; commits never outrun allocated entries.
  a_fire_ready : assert property (@(posedge clk_i) disable iff (rst_i)
    alloc_fire_i |-> alloc_ready_o);
  a_commit_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    CNT_WIDTH'(n_cmt) <= (used_q - cmt_cnt_q));

endmodule

// File: tb/tb_sb_alloc_ctrl.sv
// Scoreboard bench for sb_alloc_ctrl: driver queues expectations, negedge monitor checks them.
module tb_sb_alloc_ctrl;

  localparam int unsigned Depth = 16;
  localparam int unsigned IdxW  = 4;
  localparam int unsigned CntW  = 5;

  localparam int SRdy = 0;
  localparam int SId0 = 1;
  localparam int SId1 = 2;
  localparam int SId2 = 3;
  localparam int SId3 = 4;
  localparam int SDv  = 5;
  localparam int SDid = 6;
  localparam int SUsd = 7;
  localparam int SCmt = 8;

  logic                 clk;
  logic                 rst;
  logic [3:0]           alloc_req;
  logic                 alloc_fire;
  logic                 alloc_ready;
  logic [3:0][IdxW-1:0] alloc_id;
  logic [3:0]           commit_store;
  logic                 drain_valid;
  logic [IdxW-1:0]      drain_id;
  logic                 drain_ready;
  logic                 flush;
  logic [CntW-1:0]      used_cnt;
  logic [CntW-1:0]      cmt_cnt;

  sb_alloc_ctrl #(
    .SB_DEPTH(Depth)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_req_i   (alloc_req),
    .alloc_fire_i  (alloc_fire),
    .alloc_ready_o (alloc_ready),
    .alloc_id_o    (alloc_id),
    .commit_store_i(commit_store),
    .drain_valid_o (drain_valid),
    .drain_id_o    (drain_id),
    .drain_ready_i (drain_ready),
    .flush_i       (flush),
    .used_cnt_o    (used_cnt),
    .cmt_cnt_o     (cmt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic int actual(input int sel);
    case (sel)
      SRdy:    return int'(alloc_ready);
      SId0:    return int'(alloc_id[0]);
      SId1:    return int'(alloc_id[1]);
      SId2:    return int'(alloc_id[2]);
      SId3:    return int'(alloc_id[3]);
      SDv:     return int'(drain_valid);
      SDid:    return int'(drain_id);
      SUsd:    return int'(used_cnt);
      SCmt:    return int'(cmt_cnt);
      default: return -1;
    endcase
  endfunction

  task automatic exp_push(input string name, input int sel, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the edge and stay stable until the next edge.
  task automatic drive(input logic [3:0] req, input logic fire, input logic [3:0] cmt,
                       input logic drdy, input logic fl);
    @(posedge clk);
    #1;
    cyc++;
    rst          = 1'b0;
    alloc_req    = req;
    alloc_fire   = fire;
    commit_store = cmt;
    drain_ready  = drdy;
    flush        = fl;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst          = 1'b1;
    alloc_req    = 4'b0000;
    alloc_fire   = 1'b0;
    commit_store = 4'b0000;
    drain_ready  = 1'b0;
    flush        = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      act = actual(e.sel);
      checks++;
      if (act != e.val) begin
        errors++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.val, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    alloc_req    = 4'b0000;
    alloc_fire   = 1'b0;
    commit_store = 4'b0000;
    drain_ready  = 1'b0;
    flush        = 1'b0;

    // Reset state and first allocation.
    do_reset();
    drive(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("rst_ready", SRdy, 1);
    exp_push("rst_id0", SId0, 0);
    exp_push("rst_id1", SId1, 1);
    exp_push("rst_id2", SId2, 2);
    exp_push("rst_id3", SId3, 3);
    exp_push("rst_dvalid", SDv, 0);
    exp_push("rst_did", SDid, 0);
    exp_push("rst_used", SUsd, 0);
    exp_push("rst_cmt", SCmt, 0);
    drive(4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp_push("a1010_id0", SId0, 0);
    exp_push("a1010_id1", SId1, 0);
    exp_push("a1010_id2", SId2, 0);
    exp_push("a1010_id3", SId3, 1);
    exp_push("a1010_ready", SRdy, 1);
    drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("a1010_tail", SId0, 2);
    exp_push("a1010_used", SUsd, 2);

    // Wrap-around: move head/tail to 14, then allocate four.
    do_reset();
    for (int i = 0; i < 3; i++) drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp_push("wrap_id0", SId0, 14);
    exp_push("wrap_id1", SId1, 15);
    exp_push("wrap_id2", SId2, 0);
    exp_push("wrap_id3", SId3, 1);
    exp_push("wrap_ready", SRdy, 1);
    exp_push("wrap_dvalid", SDv, 0);
    exp_push("wrap_head", SDid, 14);
    drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("wrap_tail", SId0, 2);
    exp_push("wrap_used", SUsd, 4);

    // Full buffer, drain bypass, partial room.
    do_reset();
    for (int i = 0; i < 4; i++) drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("full_ready", SRdy, 0);
    exp_push("full_used", SUsd, 16);
    exp_push("full_cmt", SCmt, 16);
    exp_push("full_dvalid", SDv, 1);
    drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
`ifdef SB_ALLOC_BYPASS_EN
    exp_push("full_drain_ready", SRdy, 1);
`else
    exp_push("full_drain_ready", SRdy, 0);
`endif
    drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    exp_push("after_drain_ready", SRdy, 1);
    exp_push("after_drain_used", SUsd, 15);
    exp_push("after_drain_head", SDid, 1);
    drive(4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("partial_ready", SRdy, 0);
    exp_push("partial_used", SUsd, 14);
    drive(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("two_fit_ready", SRdy, 1);

    // Commit then drain.
    do_reset();
    drive(4'b0111, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp_push("cd_id0", SId0, 0);
    exp_push("cd_id1", SId1, 1);
    exp_push("cd_id2", SId2, 2);
    exp_push("cd_id3", SId3, 0);
    drive(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b0);
    exp_push("cd_pre_dvalid", SDv, 0);
    exp_push("cd_used", SUsd, 3);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("cd_cmt", SCmt, 2);
    exp_push("cd_dvalid", SDv, 1);
    exp_push("cd_did", SDid, 0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    exp_push("cd_did1", SDid, 1);
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    exp_push("cd_empty_dvalid", SDv, 0);
    exp_push("cd_head2", SDid, 2);
    exp_push("cd_cmt0", SCmt, 0);
    exp_push("cd_used1", SUsd, 1);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("cd_ignore_head", SDid, 2);
    exp_push("cd_ignore_used", SUsd, 1);

    // Flush with same-cycle commit and dropped allocation, then flush with drain.
    do_reset();
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b0);
    drive(4'b0011, 1'b1, 4'b0001, 1'b0, 1'b1);
    exp_push("fl_pre_used", SUsd, 6);
    exp_push("fl_pre_cmt", SCmt, 2);
    drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
    exp_push("fl_used", SUsd, 3);
    exp_push("fl_cmt", SCmt, 3);
    exp_push("fl_tail", SId0, 3);
    exp_push("fl_head", SDid, 0);
    drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("fl_drain_used", SUsd, 2);
    exp_push("fl_drain_cmt", SCmt, 2);
    exp_push("fl_drain_head", SDid, 1);
    exp_push("fl_drain_tail", SId0, 3);

    // Reset mid-operation.
    do_reset();
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("mid_used", SUsd, 10);
    exp_push("mid_cmt", SCmt, 4);
    exp_push("mid_dvalid", SDv, 1);
    do_reset();
    drive(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_push("mrst_used", SUsd, 0);
    exp_push("mrst_cmt", SCmt, 0);
    exp_push("mrst_dvalid", SDv, 0);
    exp_push("mrst_head", SDid, 0);
    exp_push("mrst_id0", SId0, 0);
    exp_push("mrst_id3", SId3, 3);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
